// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-packet arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_run,
  input  logic [N_REQ-1:0]   req_start,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               tx_idle,
  output logic [7:0]         tx_data,
  output logic               start_tx,
  output logic [N_REQ-1:0]   req_tx_idle,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err,
  output logic               drop_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_RELEASE} state_e;

  state_e                state_q;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         last_owner_q;
  logic [N_REQ-1:0]      grant_q;
  logic [N_REQ-1:0]      pend_q;
  logic [N_REQ-1:0][7:0] pend_data_q;
  logic [7:0]            tx_data_q;
  logic                  start_tx_q;
  logic                  start_d1_q;
  logic                  busy_q;
  logic                  timeout_err_q;
  logic                  drop_err_q;
  logic                  tx_idle_q;
  logic [CW-1:0]         cnt_q;

  logic [N_REQ-1:0]      cand;
  logic [IW-1:0]         rr_idx;
  logic [IW-1:0]         pick_idx;
  logic                  pick_ok;
  logic [7:0]            owner_data;
  logic                  owner_start;
  logic                  owner_pend;
  logic                  owner_run;
  logic                  idle_changed;
  logic                  can_release;
  logic                  timeout_hit;

  // Round-robin search starting at the requester after the last owner; the
  // loop runs backwards so the nearest candidate is the one that sticks.
  always_comb begin
    cand     = req_run | pend_q;
    pick_idx = last_owner_q;
    rr_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = IW'((int'(last_owner_q) + k) % N_REQ);
      if (cand[rr_idx]) pick_idx = rr_idx;
    end
    pick_ok = (|cand) && tx_idle;
  end

  assign owner_data   = req_data[{owner_q, 3'b000} +: 8];
  assign owner_start  = req_start[owner_q];
  assign owner_pend   = pend_q[owner_q];
  assign owner_run    = req_run[owner_q];
  assign idle_changed = (tx_idle != tx_idle_q);

  // The last start_tx must have had time to pull tx_idle low before we trust it.
  assign can_release = !owner_run && !owner_pend && !owner_start && tx_idle &&
                       !start_tx_q && !start_d1_q;
  assign timeout_hit = (cnt_q == CNT_LAST) && !owner_start && !idle_changed;

  // Arbiter FSM, pending-start buffers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      last_owner_q  <= IW'(N_REQ - 1);
      grant_q       <= '0;
      pend_q        <= '0;
      pend_data_q   <= '0;
      tx_data_q     <= '0;
      start_tx_q    <= 1'b0;
      start_d1_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_err_q    <= 1'b0;
      tx_idle_q     <= 1'b1;
      cnt_q         <= '0;
    end else begin
      start_tx_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      start_d1_q    <= start_tx_q;
      tx_idle_q     <= tx_idle;

      // Non-owner starts are parked; a second one before replay loses a byte,
      // unless the parked one is being replayed on this very grant.
      for (int i = 0; i < N_REQ; i++) begin
        if (req_start[i] && !grant_q[i]) begin
          pend_q[i]      <= 1'b1;
          pend_data_q[i] <= req_data[8*i +: 8];
          if (pend_q[i] && !(state_q == S_IDLE && pick_ok && pick_idx == IW'(i)))
            drop_err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (pick_ok) begin
            state_q <= S_OWN;
            owner_q <= pick_idx;
            grant_q <= N_REQ'(1) << pick_idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            // Replay lands together with the grant, on the first owned cycle.
            if (pend_q[pick_idx]) begin
              start_tx_q <= 1'b1;
              tx_data_q  <= pend_data_q[pick_idx];
              if (!req_start[pick_idx]) pend_q[pick_idx] <= 1'b0;
            end
          end
        end

        S_OWN: begin
          if (owner_start || idle_changed) cnt_q <= '0;
          else if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;

          if (can_release) begin
            state_q <= S_RELEASE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (timeout_hit) begin
            state_q         <= S_RELEASE;
            grant_q         <= '0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b1;
            pend_q[owner_q] <= 1'b0;
          end else if (owner_pend) begin
            // Buffered byte goes first; a colliding live start takes its slot.
            start_tx_q <= 1'b1;
            tx_data_q  <= pend_data_q[owner_q];
            if (owner_start) pend_data_q[owner_q] <= owner_data;
            else pend_q[owner_q] <= 1'b0;
          end else if (owner_start) begin
            start_tx_q <= 1'b1;
            tx_data_q  <= owner_data;
          end
        end

        S_RELEASE: begin
          last_owner_q <= owner_q;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign start_tx    = start_tx_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign drop_err    = drop_err_q;
  assign req_tx_idle = ~grant_q | {N_REQ{tx_idle}};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_run = '0;
  logic [N-1:0] req_start = '0;
  logic [8*N-1:0] req_data = '0;
  logic         tx_idle = 1'b1;
  logic [7:0]   tx_data;
  logic         start_tx;
  logic [N-1:0] req_tx_idle;
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout_err;
  logic         drop_err;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int uart_cnt = 0;
  int snap;
  int n;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_run(req_run), .req_start(req_start),
    .req_data(req_data), .tx_idle(tx_idle), .tx_data(tx_data),
    .start_tx(start_tx), .req_tx_idle(req_tx_idle), .grant(grant),
    .busy(busy), .timeout_err(timeout_err), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // UART model: busy for 4 clocks after each start pulse, counts starts.
  always @(posedge clk) begin
    if (start_tx) begin
      n_start  <= n_start + 1;
      uart_cnt <= 4;
      tx_idle  <= 1'b0;
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) tx_idle <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_byte(input int i, input logic [7:0] d);
    req_start[i] = 1'b1;
    req_data[8*i +: 8] = d;
    tick();
    req_start[i] = 1'b0;
  endtask

  task automatic wait_grant(input logic want_nonzero, input string tag);
    int k;
    k = 0;
    while (((grant != '0) != want_nonzero) && k < 60) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, k >= 60}, 32'd0);
  endtask

  task automatic wait_uart_idle(input string tag);
    int k;
    k = 0;
    while (!tx_idle && k < 30) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, tx_idle}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_run = '0;
    req_start = '0;
    tick();
    tick();
    rst = 1'b0;
    wait_uart_idle("rst_uart_idle");
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_tx", start_tx, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_tx_idle", req_tx_idle, 4'hF);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_drop", drop_err, 0);
    rst = 1'b0;
    tick();

    // 1. Single requester, three bytes
    req_run[0] = 1'b1;
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    start_byte(0, 8'hA5);
    chk("t1_st_a5", start_tx, 1);
    chk("t1_d_a5", tx_data, 8'hA5);
    tick();
    chk("t1_st_off", start_tx, 0);
    chk("t1_view", req_tx_idle, 4'b1110);
    wait_uart_idle("t1_idle_a5");
    start_byte(0, 8'h01);
    chk("t1_st_01", start_tx, 1);
    chk("t1_d_01", tx_data, 8'h01);
    tick();
    wait_uart_idle("t1_idle_01");
    start_byte(0, 8'h5A);
    chk("t1_st_5a", start_tx, 1);
    chk("t1_d_5a", tx_data, 8'h5A);
    tick();
    chk("t1_hold", tx_data, 8'h5A);
    wait_uart_idle("t1_idle_5a");
    chk("t1_owned", grant, 4'b0001);
    req_run[0] = 1'b0;
    wait_grant(1'b0, "t1_release_to");
    chk("t1_busy_off", busy, 0);
    chk("t1_n_start", n_start, 3);

    // 2. Round-robin between req0 and req2
    do_reset();
    req_run[0] = 1'b1;
    req_run[2] = 1'b1;
    wait_grant(1'b1, "t2_g1_to");
    chk("t2_first", grant, 4'b0001);
    req_run[0] = 1'b0;
    wait_grant(1'b0, "t2_r1_to");
    req_run[0] = 1'b1;
    wait_grant(1'b1, "t2_g2_to");
    chk("t2_second", grant, 4'b0100);
    req_run[2] = 1'b0;
    wait_grant(1'b0, "t2_r2_to");
    wait_grant(1'b1, "t2_g3_to");
    chk("t2_third", grant, 4'b0001);
    req_run[0] = 1'b0;
    wait_grant(1'b0, "t2_r3_to");

    // 3. Buffered start from a non-owner is replayed on grant
    do_reset();
    req_run[0] = 1'b1;
    tick();
    chk("t3_grant0", grant, 4'b0001);
    snap = n_start;
    start_byte(1, 8'h3C);
    chk("t3_no_start", start_tx, 0);
    tick();
    tick();
    chk("t3_no_leak", n_start, snap);
    chk("t3_view1", req_tx_idle[1], 1);
    req_run[0] = 1'b0;
    wait_grant(1'b0, "t3_rel_to");
    wait_grant(1'b1, "t3_g_to");
    chk("t3_grant1", grant, 4'b0010);
    chk("t3_replay_st", start_tx, 1);
    chk("t3_replay_d", tx_data, 8'h3C);
    wait_grant(1'b0, "t3_rel1_to");

    // 4. Overwritten buffered start
    do_reset();
    req_run[0] = 1'b1;
    tick();
    start_byte(3, 8'h11);
    chk("t4_no_drop", drop_err, 0);
    start_byte(3, 8'h22);
    chk("t4_drop", drop_err, 1);
    req_run[0] = 1'b0;
    wait_grant(1'b0, "t4_rel_to");
    wait_grant(1'b1, "t4_g_to");
    chk("t4_grant3", grant, 4'b1000);
    chk("t4_replay_st", start_tx, 1);
    chk("t4_replay_d", tx_data, 8'h22);
    chk("t4_sticky", drop_err, 1);
    wait_grant(1'b0, "t4_rel3_to");

    // 5. Silent owner times out
    do_reset();
    chk("t5_drop_clr", drop_err, 0);
    req_run[1] = 1'b1;
    wait_grant(1'b1, "t5_g_to");
    chk("t5_grant", grant, 4'b0010);
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("t5_cycles", n, 16);
    chk("t5_grant_off", grant, 0);
    req_run[1] = 1'b0;
    tick();
    chk("t5_pulse", timeout_err, 0);
    wait_grant(1'b0, "t5_rel_to");

    // 6. Reset mid-packet
    do_reset();
    req_run[0] = 1'b1;
    tick();
    start_byte(1, 8'h77);
    start_byte(0, 8'hA5);
    chk("t6_st", start_tx, 1);
    rst = 1'b1;
    req_run = '0;
    tick();
    chk("t6_grant", grant, 0);
    chk("t6_start", start_tx, 0);
    chk("t6_busy", busy, 0);
    chk("t6_view", req_tx_idle, 4'hF);
    rst = 1'b0;
    snap = n_start;
    wait_uart_idle("t6_inflight");
    tick();
    tick();
    tick();
    chk("t6_pend_clr", grant, 0);
    chk("t6_no_replay", n_start, snap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
